atm_account_server: RTL and testbench



---
 rtl/atm_account_server.sv | 234 +++++++++++++++++++++++
 tb/tb_atm_account_server.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_server.sv
// Bank-side account server: one request in flight through EXEC, response held in RESP.
// Optional per-session withdraw cap enabled with `define ATM_WITHDRAW_LIMIT_EN.
module atm_account_server #(
  parameter int          NUM_ACCOUNTS = 4,
  parameter int          ID_W         = 2,
  parameter int          AMT_W        = 32,
  parameter int          PIN_W        = 4,
  parameter int          MAX_TRIES    = 3,
  parameter int unsigned INIT_BALANCE = 32'h000F4240,
  parameter int unsigned DEFAULT_PIN  = 4'b1010
`ifdef ATM_WITHDRAW_LIMIT_EN
  , parameter int unsigned WITHDRAW_LIMIT = 32'd50000
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ID_W-1:0]         req_acct,
  input  logic [PIN_W-1:0]        req_pin,
  input  logic [AMT_W-1:0]        req_amount,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_status,
  output logic [AMT_W-1:0]        rsp_balance,
  output logic [NUM_ACCOUNTS-1:0] acct_locked
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef enum logic [2:0] {
    OP_VERIFY  = 3'd0,
    OP_BALANCE = 3'd1,
    OP_DEPOSIT = 3'd2,
    OP_WITHDRAW= 3'd3,
    OP_CHANGE  = 3'd4,
    OP_END     = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_BAD_PIN  = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_INSUFF   = 3'd3,
    ST_OVERFLOW = 3'd4,
    ST_BAD_OP   = 3'd5,
    ST_NOT_AUTH = 3'd6,
    ST_LIMIT    = 3'd7
  } status_t;

  state_t                  state;
  logic [AMT_W-1:0]        balance [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin_reg [NUM_ACCOUNTS];
  logic [TRY_W-1:0]        tries   [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] locked;
  logic                    sess_valid;
  logic [ID_W-1:0]         sess_acct;

  logic [2:0]              op_q;
  logic [ID_W-1:0]         acct_q;
  logic [PIN_W-1:0]        pin_q;
  logic [AMT_W-1:0]        amount_q;

  // Evaluation results for the latched request, committed on the EXEC edge
  status_t                 ev_status;
  logic [AMT_W-1:0]        ev_balance;
  logic [AMT_W-1:0]        cur_bal;
  logic [AMT_W:0]          sum;
  logic [TRY_W-1:0]        tries_inc;
  logic                    authorized;
  logic                    wr_balance;
  logic                    wr_pin;
  logic                    clr_tries;
  logic                    inc_tries;
  logic                    set_lock;
  logic                    sess_clear;
  logic                    sess_set;

`ifdef ATM_WITHDRAW_LIMIT_EN
  logic [AMT_W:0]          w_total;
  logic [AMT_W+1:0]        limit_sum;
  logic                    total_add;
`endif

  assign acct_locked = locked;

  always_comb begin
    cur_bal    = balance[acct_q];
    sum        = {1'b0, cur_bal} + {1'b0, amount_q};
    tries_inc  = tries[acct_q] + TRY_W'(1);
    authorized = sess_valid && (sess_acct == acct_q);
    ev_status  = ST_OK;
    ev_balance = cur_bal;
    wr_balance = 1'b0;
    wr_pin     = 1'b0;
    clr_tries  = 1'b0;
    inc_tries  = 1'b0;
    set_lock   = 1'b0;
    sess_clear = 1'b0;
    sess_set   = 1'b0;
`ifdef ATM_WITHDRAW_LIMIT_EN
    limit_sum  = {1'b0, w_total} + {2'b00, amount_q};
    total_add  = 1'b0;
`endif
    case (op_q)
      OP_VERIFY: begin
        sess_clear = 1'b1;
        if (locked[acct_q]) begin
          ev_status = ST_LOCKED;
        end else if (pin_q == pin_reg[acct_q]) begin
          sess_set  = 1'b1;
          clr_tries = 1'b1;
        end else begin
          inc_tries = 1'b1;
          if (tries_inc == TRY_W'(MAX_TRIES)) begin
            set_lock  = 1'b1;
            ev_status = ST_LOCKED;
          end else begin
            ev_status = ST_BAD_PIN;
          end
        end
      end
      OP_END: sess_clear = 1'b1;
      OP_BALANCE, OP_DEPOSIT, OP_WITHDRAW, OP_CHANGE: begin
        if (locked[acct_q]) begin
          ev_status = ST_LOCKED;
        end else if (!authorized) begin
          ev_status = ST_NOT_AUTH;
        end else begin
          case (op_q)
            OP_DEPOSIT: begin
              if (sum[AMT_W]) begin
                ev_status = ST_OVERFLOW;
              end else begin
                ev_balance = sum[AMT_W-1:0];
                wr_balance = 1'b1;
              end
            end
            OP_WITHDRAW: begin
`ifdef ATM_WITHDRAW_LIMIT_EN
              if (limit_sum > (AMT_W+2)'(WITHDRAW_LIMIT)) begin
                ev_status = ST_LIMIT;
              end else
`endif
              if (amount_q > cur_bal) begin
                ev_status = ST_INSUFF;
              end else begin
                ev_balance = cur_bal - amount_q;
                wr_balance = 1'b1;
`ifdef ATM_WITHDRAW_LIMIT_EN
                total_add  = 1'b1;
`endif
              end
            end
            OP_CHANGE: wr_pin = 1'b1;
            default: ;
          endcase
        end
      end
      default: ev_status = ST_BAD_OP;
    endcase
  end

  // Reset in any state discards pending work and re-initialises every account
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_status  <= 3'd0;
      rsp_balance <= '0;
      locked      <= '0;
      sess_valid  <= 1'b0;
      sess_acct   <= '0;
      op_q        <= '0;
      acct_q      <= '0;
      pin_q       <= '0;
      amount_q    <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        balance[i] <= AMT_W'(INIT_BALANCE);
        pin_reg[i] <= PIN_W'(DEFAULT_PIN);
        tries[i]   <= '0;
      end
`ifdef ATM_WITHDRAW_LIMIT_EN
      w_total     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            acct_q    <= req_acct;
            pin_q     <= req_pin;
            amount_q  <= req_amount;
            req_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (wr_balance) balance[acct_q] <= ev_balance;
          if (wr_pin)     pin_reg[acct_q] <= amount_q[PIN_W-1:0];
          if (clr_tries)  tries[acct_q]   <= '0;
          if (inc_tries)  tries[acct_q]   <= tries_inc;
          if (set_lock)   locked[acct_q]  <= 1'b1;
          if (sess_clear) sess_valid      <= 1'b0;
          if (sess_set) begin
            sess_valid <= 1'b1;
            sess_acct  <= acct_q;
          end
`ifdef ATM_WITHDRAW_LIMIT_EN
          if (sess_clear) w_total <= '0;
          if (total_add)  w_total <= w_total + {1'b0, amount_q};
`endif
          rsp_status  <= ev_status;
          rsp_balance <= ev_balance;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// Directed bench for atm_account_server: vector table plus handshake/reset sequences.
// Expected values for the withdraw cap follow `define ATM_WITHDRAW_LIMIT_EN.
module tb_atm_account_server;

  localparam logic [2:0] OP_VER = 3'd0, OP_BAL = 3'd1, OP_DEP = 3'd2,
                         OP_WDR = 3'd3, OP_CHG = 3'd4, OP_END = 3'd7;
  localparam logic [2:0] S_OK = 3'd0, S_BADPIN = 3'd1, S_LOCKED = 3'd2,
                         S_INSUFF = 3'd3, S_OVF = 3'd4, S_BADOP = 3'd5,
                         S_NOAUTH = 3'd6;
  localparam logic [31:0] INIT = 32'd1000000;
  localparam logic [3:0]  PIN0 = 4'b1010;

`ifdef ATM_WITHDRAW_LIMIT_EN
  localparam logic [2:0]  W2_ST  = 3'd7;
  localparam logic [31:0] W2_BAL = 32'hFFFF8ACF;
  localparam logic [31:0] W3_BAL = 32'hFFFF159F;
`else
  localparam logic [2:0]  W2_ST  = 3'd0;
  localparam logic [31:0] W2_BAL = 32'hFFFF159F;
  localparam logic [31:0] W3_BAL = 32'hFFFEA06F;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [1:0]  req_acct = '0;
  logic [3:0]  req_pin = '0;
  logic [31:0] req_amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_balance;
  logic [3:0]  acct_locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [1:0]  acct;
    logic [3:0]  pin;
    logic [31:0] amount;
    logic [2:0]  st;
    logic [31:0] bal;
    logic [3:0]  lk;
  } vec_t;

  vec_t vecs[$];

  atm_account_server dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .acct_locked(acct_locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] op, input logic [1:0] acct,
                        input logic [3:0] pin, input logic [31:0] amount,
                        input logic [2:0] st, input logic [31:0] bal, input logic [3:0] lk);
    vec_t v;
    v.name = name; v.op = op; v.acct = acct; v.pin = pin; v.amount = amount;
    v.st = st; v.bal = bal; v.lk = lk;
    vecs.push_back(v);
  endtask

  // Full handshake; inputs are scrambled after acceptance since they must be ignored
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] acct, input logic [3:0] pin,
                               input logic [31:0] amount, output logic [2:0] st, output logic [31:0] bal);
    int n;
    st = '0;
    bal = '0;
    @(negedge clk);
    req_op = op; req_acct = acct; req_pin = pin; req_amount = amount;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: req_ready stayed 0, required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'd5; req_acct = ~acct; req_pin = ~pin; req_amount = ~amount;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid stayed 0, required 1");
      return;
    end
    st = rsp_status;
    bal = rsp_balance;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  st;
    logic [31:0] bal;
    int n;

    addVec("dep500",        OP_DEP, 2'd0, 4'd0, 32'd500,      S_OK,     32'd1000500, 4'b0000);
    addVec("wdr_all",       OP_WDR, 2'd0, 4'd0, 32'd1000500,  S_OK,     32'd0,       4'b0000);
    addVec("wdr_insuff",    OP_WDR, 2'd0, 4'd0, 32'd1,        S_INSUFF, 32'd0,       4'b0000);
    addVec("dep_zero",      OP_DEP, 2'd0, 4'd0, 32'd0,        S_OK,     32'd0,       4'b0000);
    addVec("bal_other",     OP_BAL, 2'd2, 4'd0, 32'd0,        S_NOAUTH, INIT,        4'b0000);
    addVec("bad_op",        3'd5,   2'd0, 4'd0, 32'd0,        S_BADOP,  32'd0,       4'b0000);
    addVec("a1_bad1",       OP_VER, 2'd1, 4'd1, 32'd0,        S_BADPIN, INIT,        4'b0000);
    addVec("a1_bad2",       OP_VER, 2'd1, 4'd1, 32'd0,        S_BADPIN, INIT,        4'b0000);
    addVec("a1_bad3",       OP_VER, 2'd1, 4'd1, 32'd0,        S_LOCKED, INIT,        4'b0010);
    addVec("a1_good_lock",  OP_VER, 2'd1, PIN0, 32'd0,        S_LOCKED, INIT,        4'b0010);
    addVec("a3_verify",     OP_VER, 2'd3, PIN0, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a2_noauth",     OP_BAL, 2'd2, 4'd0, 32'd0,        S_NOAUTH, INIT,        4'b0010);
    addVec("a3_balance",    OP_BAL, 2'd3, 4'd0, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a3_chgpin",     OP_CHG, 2'd3, 4'd0, 32'd5,        S_OK,     INIT,        4'b0010);
    addVec("a3_end",        OP_END, 2'd3, 4'd0, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a3_after_end",  OP_BAL, 2'd3, 4'd0, 32'd0,        S_NOAUTH, INIT,        4'b0010);
    addVec("a3_oldpin",     OP_VER, 2'd3, PIN0, 32'd0,        S_BADPIN, INIT,        4'b0010);
    addVec("a3_newpin",     OP_VER, 2'd3, 4'd5, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a3_bad_a",      OP_VER, 2'd3, 4'd0, 32'd0,        S_BADPIN, INIT,        4'b0010);
    addVec("a3_bad_b",      OP_VER, 2'd3, 4'd0, 32'd0,        S_BADPIN, INIT,        4'b0010);
    addVec("a3_ok_clear",   OP_VER, 2'd3, 4'd5, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a3_bad_c",      OP_VER, 2'd3, 4'd0, 32'd0,        S_BADPIN, INIT,        4'b0010);
    addVec("a3_fail_clrs",  OP_BAL, 2'd3, 4'd0, 32'd0,        S_NOAUTH, INIT,        4'b0010);
    addVec("a2_verify",     OP_VER, 2'd2, PIN0, 32'd0,        S_OK,     INIT,        4'b0010);
    addVec("a2_dep_big",    OP_DEP, 2'd2, 4'd0, 32'hFFF0BDB0, S_OK,     32'hFFFFFFF0, 4'b0010);
    addVec("a2_ovf",        OP_DEP, 2'd2, 4'd0, 32'h20,       S_OVF,    32'hFFFFFFF0, 4'b0010);
    addVec("a2_dep_max",    OP_DEP, 2'd2, 4'd0, 32'hF,        S_OK,     32'hFFFFFFFF, 4'b0010);
    addVec("a2_ovf_one",    OP_DEP, 2'd2, 4'd0, 32'h1,        S_OVF,    32'hFFFFFFFF, 4'b0010);
    addVec("a2_wdr1",       OP_WDR, 2'd2, 4'd0, 32'd30000,    S_OK,     32'hFFFF8ACF, 4'b0010);
    addVec("a2_wdr2",       OP_WDR, 2'd2, 4'd0, 32'd30000,    W2_ST,    W2_BAL,      4'b0010);
    addVec("a2_end",        OP_END, 2'd2, 4'd0, 32'd0,        S_OK,     W2_BAL,      4'b0010);
    addVec("a2_reverify",   OP_VER, 2'd2, PIN0, 32'd0,        S_OK,     W2_BAL,      4'b0010);
    addVec("a2_wdr3",       OP_WDR, 2'd2, 4'd0, 32'd30000,    S_OK,     W3_BAL,      4'b0010);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready",   32'(req_ready),   32'd1);
    checkOutput("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    checkOutput("rst_rsp_status",  32'(rsp_status),  32'd0);
    checkOutput("rst_rsp_balance", rsp_balance,      32'd0);
    checkOutput("rst_locked",      32'(acct_locked), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First request: response appears on the second edge counting the accept edge
    @(negedge clk);
    req_op = OP_VER; req_acct = 2'd0; req_pin = PIN0; req_amount = '0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("lat_exec_valid", 32'(rsp_valid), 32'd0);
    checkOutput("lat_exec_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_resp_valid",  32'(rsp_valid),  32'd1);
    checkOutput("lat_resp_status", 32'(rsp_status), 32'(S_OK));
    checkOutput("lat_resp_bal",    rsp_balance,     INIT);
    @(posedge clk);
    #1;
    checkOutput("lat_done_valid", 32'(rsp_valid), 32'd0);
    checkOutput("lat_done_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].acct, vecs[i].pin, vecs[i].amount, st, bal);
      checkOutput({vecs[i].name, "_status"}, 32'(st), 32'(vecs[i].st));
      checkOutput({vecs[i].name, "_bal"},    bal,     vecs[i].bal);
      checkOutput({vecs[i].name, "_locked"}, 32'(acct_locked), 32'(vecs[i].lk));
    end

    // Response back-pressure: outputs must hold while rsp_ready is low
    @(negedge clk);
    req_op = OP_BAL; req_acct = 2'd2; req_pin = '0; req_amount = '0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_valid",  32'(rsp_valid),  32'd1);
      checkOutput("stall_status", 32'(rsp_status), 32'(S_OK));
      checkOutput("stall_bal",    rsp_balance,     W3_BAL);
      checkOutput("stall_ready",  32'(req_ready),  32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("stall_release_ready", 32'(req_ready), 32'd1);

    // Reset clears the lock on account 1
    pulseReset();
    checkOutput("reset_unlock", 32'(acct_locked), 32'd0);
    applyStimulus(OP_VER, 2'd1, PIN0, 32'd0, st, bal);
    checkOutput("a1_unlocked_status", 32'(st), 32'(S_OK));
    checkOutput("a1_unlocked_bal",    bal,     INIT);

    // Reset while in EXEC discards the deposit
    @(negedge clk);
    req_op = OP_DEP; req_acct = 2'd1; req_pin = '0; req_amount = 32'd100;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    checkOutput("exec_reset_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(OP_VER, 2'd1, PIN0, 32'd0, st, bal);
    checkOutput("exec_reset_bal", bal, INIT);

    // Reset while in RESP drops the response and restores the balance
    @(negedge clk);
    req_op = OP_DEP; req_acct = 2'd1; req_pin = '0; req_amount = 32'd100;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resp_pre_bal", rsp_balance, INIT + 32'd100);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    checkOutput("resp_reset_valid",  32'(rsp_valid),  32'd0);
    checkOutput("resp_reset_status", 32'(rsp_status), 32'd0);
    checkOutput("resp_reset_bal",    rsp_balance,     32'd0);
    rsp_ready = 1'b1;
    applyStimulus(OP_VER, 2'd1, PIN0, 32'd0, st, bal);
    checkOutput("resp_reset_after_bal", bal, INIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
